// File: rtl/ukf_pkg.sv
// Shared types and constants for the 4-lane sum sequencer.
package ukf_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 4;
  localparam int WORD_W = 128;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam logic [15:0] BYTEEN_ALL = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CAP,
    S_ACC,
    S_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/ukf_lane_packer.sv
// Lane counter plus 128-bit result register; each load drops one 32-bit sum
// into the current lane, lane 0 landing in the low bits.
module ukf_lane_packer
  import ukf_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [LANE_W-1:0] i_sum,
  output logic              o_last,
  output logic [WORD_W-1:0] o_word
);

  logic [LANE_IDX_W-1:0] r_lane;
  logic [WORD_W-1:0]     r_word;

  // The lane index wraps from the last lane back to 0 on its own, so a
  // full word needs no explicit clear. The word itself is never cleared
  // between jobs: unfilled lanes keep their previous contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_load) begin
      r_word[r_lane*LANE_W +: LANE_W] <= i_sum;
      r_lane <= r_lane + LANE_IDX_W'(1);
    end
  end

  assign o_last = (r_lane == LANE_IDX_W'(LANES - 1));
  assign o_word = r_word;

endmodule

// File: rtl/ukf_sum_sequencer.sv
// Sequences the 4-lane sum datapath against the 64 x 128-bit RAM: read a
// source word, split it into four operands, pack four sums, write one word.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | issue read of SRC_BASE+src_idx
// WAIT   | extra read latency cycles (RD_LAT>1 only)
// CAP    | readdata registered into op_a..op_d
// ACC    | dp_sum loaded into current result lane, src_idx++
// WR     | write packed word to DST_BASE+src_idx/4-1
// DONE   | one-cycle done pulse
module ukf_sum_sequencer
  import ukf_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 32,
  parameter int NUM_SRC  = 32,
  parameter int RD_LAT   = 1
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_chipselect,
  output logic              o_read,
  output logic              o_write,
  output logic              o_clken,
  output logic [15:0]       o_byteenable,
  input  logic [WORD_W-1:0] i_readdata,
  output logic [WORD_W-1:0] o_writedata,
  output logic [LANE_W-1:0] o_op_a,
  output logic [LANE_W-1:0] o_op_b,
  output logic [LANE_W-1:0] o_op_c,
  output logic [LANE_W-1:0] o_op_d,
  input  logic [LANE_W-1:0] i_dp_sum
);

  localparam int CNT_W  = $clog2(NUM_SRC + 1);
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  generate
    if (NUM_SRC <= 0 || (NUM_SRC % LANES) != 0) begin : g_bad_num_src
      $error("ukf_sum_sequencer: NUM_SRC must be a positive multiple of 4");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
      $error("ukf_sum_sequencer: RD_LAT must be at least 1");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_src_idx;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WORD_W-1:0]   r_ops;
  logic                w_clear;
  logic                w_load;
  logic                w_cap;
  logic                w_last;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

  // src_idx has already been bumped past the fourth word when WR runs.
  assign w_rd_addr = ADDR_W'(SRC_BASE) + ADDR_W'(r_src_idx);
  assign w_wr_addr = ADDR_W'(DST_BASE) + ADDR_W'(r_src_idx >> 2) - ADDR_W'(1);

  always_ff @(posedge i_clock) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_address   = '0;
    o_read      = 1'b0;
    o_write     = 1'b0;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        o_address   = w_rd_addr;
        o_read      = 1'b1;
        w_state_nxt = (RD_LAT > 1) ? S_WAIT : S_CAP;
      end
      S_WAIT: begin
        if (r_wait_cnt == WAIT_W'(1)) w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_cap       = 1'b1;
        w_state_nxt = S_ACC;
      end
      S_ACC: begin
        w_load      = 1'b1;
        w_state_nxt = w_last ? S_WR : S_RD;
      end
      S_WR: begin
        o_address   = w_wr_addr;
        o_write     = 1'b1;
        w_state_nxt = (r_src_idx == CNT_W'(NUM_SRC)) ? S_DONE : S_RD;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read-latency timer: a down-counter loaded during RD, leaving WAIT at 1.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_src_idx  <= '0;
      r_wait_cnt <= '0;
      r_ops      <= '0;
    end else begin
      if (w_clear)     r_src_idx <= '0;
      else if (w_load) r_src_idx <= r_src_idx + CNT_W'(1);

      if (r_state == S_RD)        r_wait_cnt <= WAIT_W'(RD_LAT - 1);
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - WAIT_W'(1);

      if (w_cap) r_ops <= i_readdata;
    end
  end

  ukf_lane_packer u_packer (
    .i_clk   (i_clock),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_sum   (i_dp_sum),
    .o_last  (w_last),
    .o_word  (o_writedata)
  );

  assign o_op_a       = r_ops[127:96];
  assign o_op_b       = r_ops[95:64];
  assign o_op_c       = r_ops[63:32];
  assign o_op_d       = r_ops[31:0];
  assign o_chipselect = o_read | o_write;
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_clken      = 1'b1;
  assign o_byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_ukf_sum_sequencer.sv
// Bench for ukf_sum_sequencer: three builds (4 words, 32 words, 4 words with
// two-cycle RAM latency) checked against a word-level sum model.
module tb_ukf_sum_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst   [3];
  logic         start [3];
  logic         busy  [3];
  logic         done  [3];
  logic         cs    [3];
  logic         rd    [3];
  logic         wr    [3];
  logic         clken [3];
  logic [5:0]   addr  [3];
  logic [15:0]  be    [3];
  logic [127:0] rdata [3];
  logic [127:0] wdata [3];
  logic [31:0]  opa   [3];
  logic [31:0]  opb   [3];
  logic [31:0]  opc   [3];
  logic [31:0]  opd   [3];
  logic [31:0]  dsum  [3];
  logic [127:0] mem   [3][64];

  int total = 0;
  int bad   = 0;

  logic [133:0] exp_q[$];
  int           act = -1;
  int           wr_count [3] = '{0, 0, 0};
  logic [5:0]   last_waddr [3];
  logic [127:0] last_wdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [127:0] pipe1;
    logic [127:0] pipe2;

    ukf_sum_sequencer #(
      .NUM_SRC (g == 1 ? 32 : 4),
      .RD_LAT  (g == 2 ? 2 : 1)
    ) u_dut (
      .i_clock      (clk),
      .i_rst        (rst[g]),
      .i_start      (start[g]),
      .o_busy       (busy[g]),
      .o_done       (done[g]),
      .o_address    (addr[g]),
      .o_chipselect (cs[g]),
      .o_read       (rd[g]),
      .o_write      (wr[g]),
      .o_clken      (clken[g]),
      .o_byteenable (be[g]),
      .i_readdata   (rdata[g]),
      .o_writedata  (wdata[g]),
      .o_op_a       (opa[g]),
      .o_op_b       (opb[g]),
      .o_op_c       (opc[g]),
      .o_op_d       (opd[g]),
      .i_dp_sum     (dsum[g])
    );

    assign dsum[g] = opa[g] + opb[g] + opc[g] + opd[g];

    always @(posedge clk) begin
      if (rd[g]) pipe1 <= mem[g][addr[g]];
      pipe2 <= pipe1;
    end
    assign rdata[g] = (g == 2) ? pipe2 : pipe1;
  end

  // Expected packed word k: lane l holds the 32-bit wrapped sum of source word 4k+l.
  function automatic logic [127:0] model_word(input int g, input int k);
    logic [127:0] w;
    logic [127:0] m;
    logic [31:0]  s;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      m = mem[g][k*4 + l];
      s = m[127:96] + m[95:64] + m[63:32] + m[31:0];
      w[l*32 +: 32] = s;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [133:0] e;
    for (int g = 0; g < 3; g++) begin
      total++;
      if ((rd[g] && wr[g]) || (cs[g] !== (rd[g] | wr[g])) || clken[g] !== 1'b1 || be[g] !== 16'hFFFF) begin
        bad++;
        $display("FAIL strobes inst%0d: rd=%b wr=%b cs=%b clken=%b be=%h", g, rd[g], wr[g], cs[g], clken[g], be[g]);
      end
      if (wr[g]) begin
        total++;
        wr_count[g]   = wr_count[g] + 1;
        last_waddr[g] = addr[g];
        last_wdata[g] = wdata[g];
        if (exp_q.size() == 0 || act != g) begin
          bad++;
          $display("FAIL unexpected_write inst%0d: addr=%0d data=%h expected no write", g, addr[g], wdata[g]);
        end else begin
          e = exp_q.pop_front();
          if ({addr[g], wdata[g]} !== e) begin
            bad++;
            $display("FAIL write inst%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                     g, addr[g], wdata[g], e[133:128], e[127:0]);
          end
        end
      end
    end
  end

  int done_cyc, busy_cyc, done_cnt, rd_cyc, op_cyc, writes;

  task automatic run_job(input int g, input int n, input int restart_at, input int rst_at);
    int w0;
    logic [31:0] op0;
    act = g;
    if (rst_at == 0)
      for (int k = 0; k < n/4; k++) exp_q.push_back({6'(32 + k), model_word(g, k)});
    w0  = wr_count[g];
    op0 = opa[g];
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
    done_cyc = 0; busy_cyc = 0; done_cnt = 0; rd_cyc = 0; op_cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      if (busy[g]) busy_cyc++;
      if (done[g]) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (rd[g] && rd_cyc == 0) rd_cyc = c;
      if (opa[g] !== op0 && op_cyc == 0) op_cyc = c;
      start[g] = (c == restart_at);
      rst[g]   = (c == rst_at);
      @(negedge clk);
    end
    start[g] = 1'b0;
    rst[g]   = 1'b0;
    writes = wr_count[g] - w0;
    chk("writes_drained", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g]   = 1'b1;
      start[g] = 1'b0;
      for (int i = 0; i < 64; i++) mem[g][i] = '0;
    end
    for (int g = 0; g < 3; g += 2) begin
      mem[g][0] = {32'd1, 32'd2, 32'd3, 32'd4};
      mem[g][1] = {32'd10, 32'd20, 32'd30, 32'd40};
      mem[g][2] = {32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
      mem[g][3] = {32'd5, 32'd5, 32'd5, 32'd5};
    end
    for (int i = 0; i < 32; i++) mem[1][i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_read",  128'(rd[g]),    128'(0));
      chk("rst_write", 128'(wr[g]),    128'(0));
      chk("rst_cs",    128'(cs[g]),    128'(0));
      chk("rst_busy",  128'(busy[g]),  128'(0));
      chk("rst_done",  128'(done[g]),  128'(0));
      chk("rst_addr",  128'(addr[g]),  128'(0));
      chk("rst_be",    128'(be[g]),    128'(16'hFFFF));
      chk("rst_clken", 128'(clken[g]), 128'(1));
      chk("rst_wdata", wdata[g],       128'(0));
      chk("rst_opa",   128'(opa[g]),   128'(0));
    end

    chk("model_pin", model_word(0, 0), {32'd20, 32'd0, 32'd100, 32'd10});

    // 4-word job, RD_LAT=1
    run_job(0, 4, 0, 0);
    chk("n4_done_cycle", 128'(done_cyc), 128'(14));
    chk("n4_busy_cycles", 128'(busy_cyc), 128'(13));
    chk("n4_done_pulses", 128'(done_cnt), 128'(1));
    chk("n4_writes", 128'(writes), 128'(1));
    chk("n4_addr", 128'(last_waddr[0]), 128'(32));
    chk("n4_data", last_wdata[0], {32'd20, 32'd0, 32'd100, 32'd10});
    chk("n4_op_latency", 128'(op_cyc - rd_cyc), 128'(2));

    // 32-word job with random contents
    run_job(1, 32, 0, 0);
    chk("n32_done_cycle", 128'(done_cyc), 128'(105));
    chk("n32_busy_cycles", 128'(busy_cyc), 128'(104));
    chk("n32_done_pulses", 128'(done_cnt), 128'(1));
    chk("n32_writes", 128'(writes), 128'(8));
    chk("n32_last_addr", 128'(last_waddr[1]), 128'(39));

    // start re-pulsed mid-job
    run_job(0, 4, 5, 0);
    chk("restart_done_cycle", 128'(done_cyc), 128'(14));
    chk("restart_done_pulses", 128'(done_cnt), 128'(1));
    chk("restart_writes", 128'(writes), 128'(1));

    // reset before the write
    run_job(0, 4, 0, 9);
    chk("rst_job_done_pulses", 128'(done_cnt), 128'(0));
    chk("rst_job_writes", 128'(writes), 128'(0));
    chk("rst_job_busy_after", 128'(busy[0]), 128'(0));
    chk("rst_job_wdata", wdata[0], 128'(0));

    run_job(0, 4, 0, 0);
    chk("after_rst_done_cycle", 128'(done_cyc), 128'(14));
    chk("after_rst_writes", 128'(writes), 128'(1));
    chk("after_rst_data", last_wdata[0], {32'd20, 32'd0, 32'd100, 32'd10});

    // RD_LAT=2 build
    run_job(2, 4, 0, 0);
    chk("lat2_done_cycle", 128'(done_cyc), 128'(18));
    chk("lat2_busy_cycles", 128'(busy_cyc), 128'(17));
    chk("lat2_done_pulses", 128'(done_cnt), 128'(1));
    chk("lat2_writes", 128'(writes), 128'(1));
    chk("lat2_op_latency", 128'(op_cyc - rd_cyc), 128'(3));
    chk("lat2_addr", 128'(last_waddr[2]), 128'(32));
    chk("lat2_data", last_wdata[2], {32'd20, 32'd0, 32'd100, 32'd10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
